// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the step sequencer slice.
//   step_entry_t : one pattern RAM entry (active flag + note code)
//   seq_state_t  : sequencer control state (IDLE / PLAY)
//   SEQ_NOTE_W   : note code width stored in a pattern entry
//   DEFAULT_PERIOD : suggested tempo (cycles per step) for integrators
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int SEQ_NOTE_W     = 3;
    localparam int DEFAULT_PERIOD = 1000;

    typedef struct packed {
        logic                  active;
        logic [SEQ_NOTE_W-1:0] note;
    } step_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } seq_state_t;

endpackage

// File: rtl/step_timer.sv
// -----------------------------------------------------------------------------
// step_timer
// Latches the tempo/gate settings at step entry, counts cycles within the
// step and reports the last cycle of the step plus the gate window.
// Optional feature macro: STEP_SEQUENCER_SWING_EN (adds swing / even_step).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : hold the cycle counter at 0 (sequencer idle)
//   start        : step entry on this edge; latch settings, restart count
//   even_step    : (swing only) entering step has an even index
//   period       : cycles per step, 0 treated as 1
//   gate_cycles  : gate-high cycles, 0 or >= duration means whole step
//   swing        : (swing only) cycles moved from odd to even steps
//   step_done    : current cycle is the last cycle of the step
//   gate_window  : gate may sound in the current cycle
// -----------------------------------------------------------------------------
module step_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                start,
`ifdef STEP_SEQUENCER_SWING_EN
    input  logic                even_step,
    input  logic [PERIOD_W-1:0] swing,
`endif
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] gate_cycles,
    output logic                step_done,
    output logic                gate_window
);

    // One extra bit so an even step stretched by swing (up to 2*period-1)
    // still fits in the counter and the latched duration.
    localparam int CNT_W = PERIOD_W + 1;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    dur_lat;
    logic [CNT_W-1:0]    dur_next;
    logic [PERIOD_W-1:0] gate_lat;
    logic [PERIOD_W-1:0] period_eff;

    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;

`ifdef STEP_SEQUENCER_SWING_EN
    logic [PERIOD_W-1:0] swing_lat;
    logic [PERIOD_W-1:0] swing_eff;

    // Swing is captured (and clamped) on the even step and reused by the
    // odd step that follows it.
    always_comb begin
        swing_eff = swing_lat;
        dur_next  = CNT_W'(1);
        if (even_step) begin
            swing_eff = (swing > period_eff - 1'b1) ? period_eff - 1'b1 : swing;
            dur_next  = {1'b0, period_eff} + {1'b0, swing_eff};
        end else if (period_eff > swing_eff) begin
            dur_next  = {1'b0, period_eff - swing_eff};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            swing_lat <= '0;
        end else if (start) begin
            swing_lat <= swing_eff;
        end
    end
`else
    assign dur_next = {1'b0, period_eff};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            dur_lat  <= CNT_W'(1);
            gate_lat <= '0;
        end else if (start) begin
            cnt      <= '0;
            dur_lat  <= dur_next;
            gate_lat <= gate_cycles;
        end else if (clear) begin
            cnt      <= '0;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    assign step_done   = (cnt == dur_lat - 1'b1);
    assign gate_window = (gate_lat == '0) ||
                         ({1'b0, gate_lat} >= dur_lat) ||
                         ({1'b0, gate_lat} > cnt);

endmodule

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Pattern step sequencer: a NUM_STEPS-entry pattern RAM played at a
// programmable tempo, loop length and gate length. Feeds note code, gate and
// step index to the pwm_decoder / pwm_generator chain.
// Optional feature macro: STEP_SEQUENCER_SWING_EN (adds swing_i).
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   run_i           : 1 = play, 0 = stop at the end of the current step
//   step_period_i   : cycles per step (0 treated as 1), sampled at step entry
//   gate_cycles_i   : gate-high cycles per active step, sampled at step entry
//   loop_last_i     : index of the last step in the loop
//   swing_i         : (swing only) extra cycles on even steps, taken from odd
//   wr_en_i/wr_addr_i/wr_note_i/wr_active_i : pattern RAM write port
//   beat_count      : current step index
//   note_o          : note code latched at step entry
//   gate_o          : note sounding
//   step_strobe_o   : one-cycle pulse in the first cycle of each step
//
// Handshake: there is none; run_i is a level, wr_en_i is a single-cycle
// strobe accepted unconditionally on the edge where it is high.
// The pattern entry width follows seq_pkg::SEQ_NOTE_W, so NOTE_W must match it.
// -----------------------------------------------------------------------------
module step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS = 16,
    parameter int NOTE_W    = 3,
    parameter int PERIOD_W  = 24,
    parameter int STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic [PERIOD_W-1:0] step_period_i,
    input  logic [PERIOD_W-1:0] gate_cycles_i,
    input  logic [STEP_W-1:0]   loop_last_i,
`ifdef STEP_SEQUENCER_SWING_EN
    input  logic [PERIOD_W-1:0] swing_i,
`endif
    input  logic                wr_en_i,
    input  logic [STEP_W-1:0]   wr_addr_i,
    input  logic [NOTE_W-1:0]   wr_note_i,
    input  logic                wr_active_i,
    output logic [STEP_W-1:0]   beat_count,
    output logic [NOTE_W-1:0]   note_o,
    output logic                gate_o,
    output logic                step_strobe_o
);

    step_entry_t ram [NUM_STEPS];
    seq_state_t  state;
    logic        active_lat;
    logic [STEP_W-1:0] next_beat;
    logic        entering;
    logic        stopping;
    logic        timer_clear;
    logic        step_done;
    logic        gate_window;

    // Using ">=" rather than "==" makes the loop wrap even when loop_last_i
    // is lowered below the step currently playing.
    always_comb begin
        next_beat = '0;
        if (state == PLAY && beat_count < loop_last_i) begin
            next_beat = beat_count + 1'b1;
        end
        entering    = run_i && (state == IDLE || step_done);
        stopping    = (state == PLAY) && step_done && !run_i;
        timer_clear = (state == IDLE && !run_i) || stopping;
    end

    step_timer #(
        .PERIOD_W   (PERIOD_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .start      (entering),
`ifdef STEP_SEQUENCER_SWING_EN
        .even_step  (~next_beat[0]),
        .swing      (swing_i),
`endif
        .period     (step_period_i),
        .gate_cycles(gate_cycles_i),
        .step_done  (step_done),
        .gate_window(gate_window)
    );

    // RAM reads use the pre-edge contents, so a write landing on the entry
    // edge of the same address is only seen on the next visit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat_count    <= '0;
            note_o        <= '0;
            active_lat    <= 1'b0;
            step_strobe_o <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                ram[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                ram[wr_addr_i] <= '{active: wr_active_i, note: wr_note_i};
            end
            step_strobe_o <= 1'b0;
            if (entering) begin
                state         <= PLAY;
                beat_count    <= next_beat;
                note_o        <= ram[next_beat].note;
                active_lat    <= ram[next_beat].active;
                step_strobe_o <= 1'b1;
            end else if (stopping) begin
                state         <= IDLE;
                beat_count    <= '0;
                note_o        <= '0;
                active_lat    <= 1'b0;
            end
        end
    end

    assign gate_o = active_lat & gate_window;

endmodule

// File: tb/tb_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_step_sequencer
// Self-checking bench for step_sequencer: reset checks, a vector table of
// whole-run summaries, hand-written corner sequences and randomized runs
// compared against a per-cycle arithmetic reference model.
// Optional feature macro: STEP_SEQUENCER_SWING_EN (adds swing checks).
// -----------------------------------------------------------------------------
module tb_step_sequencer;

    localparam int NUM_STEPS = 16;
    localparam int NOTE_W    = 3;
    localparam int PERIOD_W  = 24;
    localparam int STEP_W    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                run_i = 1'b0;
    logic [PERIOD_W-1:0] step_period_i = '0;
    logic [PERIOD_W-1:0] gate_cycles_i = '0;
    logic [STEP_W-1:0]   loop_last_i = '0;
`ifdef STEP_SEQUENCER_SWING_EN
    logic [PERIOD_W-1:0] swing_i = '0;
`endif
    logic                wr_en_i = 1'b0;
    logic [STEP_W-1:0]   wr_addr_i = '0;
    logic [NOTE_W-1:0]   wr_note_i = '0;
    logic                wr_active_i = 1'b0;
    logic [STEP_W-1:0]   beat_count;
    logic [NOTE_W-1:0]   note_o;
    logic                gate_o;
    logic                step_strobe_o;

    step_sequencer #(
        .NUM_STEPS    (NUM_STEPS),
        .NOTE_W       (NOTE_W),
        .PERIOD_W     (PERIOD_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .step_period_i(step_period_i),
        .gate_cycles_i(gate_cycles_i),
        .loop_last_i  (loop_last_i),
`ifdef STEP_SEQUENCER_SWING_EN
        .swing_i      (swing_i),
`endif
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_note_i    (wr_note_i),
        .wr_active_i  (wr_active_i),
        .beat_count   (beat_count),
        .note_o       (note_o),
        .gate_o       (gate_o),
        .step_strobe_o(step_strobe_o)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    int m_active [NUM_STEPS];
    int m_note   [NUM_STEPS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        run_i   = 1'b0;
        wr_en_i = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM_STEPS; i++) begin
            m_active[i] = 0;
            m_note[i]   = 0;
        end
    endtask

    task automatic write_step(input int addr, input int act, input int note);
        wr_en_i     = 1'b1;
        wr_addr_i   = addr[STEP_W-1:0];
        wr_active_i = act[0];
        wr_note_i   = note[NOTE_W-1:0];
        m_active[addr] = act;
        m_note[addr]   = note;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) write_step(i, 1, i + 1);
    endtask

    task automatic set_cfg(input int p, input int g, input int l);
        step_period_i = p[PERIOD_W-1:0];
        gate_cycles_i = g[PERIOD_W-1:0];
        loop_last_i   = l[STEP_W-1:0];
    endtask

    // Reference: cycle t after the run edge, constant settings, no swing.
    task automatic model_at(input int t, input int p, input int g, input int l,
                            output int e_beat, output int e_note,
                            output int e_gate, output int e_strobe);
        int pe, k, b;
        pe = (p == 0) ? 1 : p;
        k  = t % pe;
        b  = (t / pe) % (l + 1);
        e_beat   = b;
        e_note   = m_note[b];
        e_strobe = (k == 0) ? 1 : 0;
        e_gate   = (m_active[b] != 0 && (g == 0 || g >= pe || k < g)) ? 1 : 0;
    endtask

    task automatic check_idle(input string tag);
        check($sformatf("%s idle beat", tag), 32'(beat_count), 0);
        check($sformatf("%s idle note", tag), 32'(note_o), 0);
        check($sformatf("%s idle gate", tag), 32'(gate_o), 0);
        check($sformatf("%s idle strobe", tag), 32'(step_strobe_o), 0);
    endtask

    task automatic run_model(input string tag, input int p, input int g, input int l, input int n);
        int eb, en, eg, es, pe;
        pe = (p == 0) ? 1 : p;
        set_cfg(p, g, l);
        run_i = 1'b1;
        for (int t = 0; t < n; t++) begin
            tick();
            model_at(t, p, g, l, eb, en, eg, es);
            check($sformatf("%s beat t=%0d", tag, t), 32'(beat_count), eb);
            check($sformatf("%s note t=%0d", tag, t), 32'(note_o), en);
            check($sformatf("%s gate t=%0d", tag, t), 32'(gate_o), eg);
            check($sformatf("%s strobe t=%0d", tag, t), 32'(step_strobe_o), es);
        end
        run_i = 1'b0;
        // The step in progress finishes, then the sequencer goes idle.
        for (int t = n; t < n + pe + 1; t++) begin
            tick();
            if (t % pe == 0) begin
                check_idle(tag);
                break;
            end
            model_at(t, p, g, l, eb, en, eg, es);
            check($sformatf("%s tail beat t=%0d", tag, t), 32'(beat_count), eb);
            check($sformatf("%s tail gate t=%0d", tag, t), 32'(gate_o), eg);
        end
        tick();
        check_idle({tag, " stay"});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int p, g, l, c;
        int exp_strobes, exp_gate_hi, exp_beat;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int strobes, gate_hi;
        int exp_notes [5];
        int pos_q [$];
        int exp_q [$];

        tbl[0] = '{4, 2, 3, 20, 5, 10, 0};
        tbl[1] = '{4, 0, 3, 16, 4, 16, 3};
        tbl[2] = '{4, 4, 3, 16, 4, 16, 3};
        tbl[3] = '{0, 0, 3,  8, 8,  8, 3};
        tbl[4] = '{3, 1, 7, 24, 8,  4, 7};
        tbl[5] = '{2, 1, 0, 10, 5,  5, 0};
        tbl[6] = '{5, 9, 1, 10, 2, 10, 1};

        // Reset state
        do_reset();
        check_idle("reset");

        // Table: whole-run summaries with pattern 0..3 = active notes 1..4
        for (int v = 0; v < 7; v++) begin
            do_reset();
            load_basic();
            set_cfg(tbl[v].p, tbl[v].g, tbl[v].l);
            run_i = 1'b1;
            strobes = 0;
            gate_hi = 0;
            for (int t = 0; t < tbl[v].c; t++) begin
                tick();
                strobes += int'(step_strobe_o);
                gate_hi += int'(gate_o);
            end
            check($sformatf("vec%0d strobes", v), strobes, tbl[v].exp_strobes);
            check($sformatf("vec%0d gate_hi", v), gate_hi, tbl[v].exp_gate_hi);
            check($sformatf("vec%0d beat", v), 32'(beat_count), tbl[v].exp_beat);
        end

        // Basic play: notes 1,2,3,4,1 with gate 2 of 4
        do_reset();
        load_basic();
        exp_notes = '{1, 2, 3, 4, 1};
        set_cfg(4, 2, 3);
        run_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            check($sformatf("basic strobe t=%0d", t), 32'(step_strobe_o), (t % 4 == 0) ? 1 : 0);
            check($sformatf("basic gate t=%0d", t), 32'(gate_o), (t % 4 < 2) ? 1 : 0);
            check($sformatf("basic beat t=%0d", t), 32'(beat_count), (t / 4) % 4);
            check($sformatf("basic note t=%0d", t), 32'(note_o), exp_notes[t / 4]);
        end

        // Rest step: step 2 silent but still strobed
        do_reset();
        load_basic();
        write_step(2, 0, 0);
        set_cfg(4, 2, 3);
        run_i = 1'b1;
        for (int t = 0; t < 16; t++) begin
            tick();
            if (t >= 8 && t < 12) begin
                check($sformatf("rest gate t=%0d", t), 32'(gate_o), 0);
                check($sformatf("rest note t=%0d", t), 32'(note_o), 0);
            end
            if (t == 8) check("rest strobe", 32'(step_strobe_o), 1);
        end

        // Stop mid-step: step 1 completes, then idle; re-run from step 0
        do_reset();
        load_basic();
        set_cfg(8, 0, 3);
        run_i = 1'b1;
        for (int t = 0; t < 24; t++) begin
            tick();
            if (t < 16) begin
                check($sformatf("stop beat t=%0d", t), 32'(beat_count), t / 8);
                check($sformatf("stop gate t=%0d", t), 32'(gate_o), 1);
            end else begin
                check_idle($sformatf("stop t=%0d", t));
            end
            if (t == 9) run_i = 1'b0;
        end
        run_i = 1'b1;
        tick();
        check("rerun strobe", 32'(step_strobe_o), 1);
        check("rerun beat", 32'(beat_count), 0);
        check("rerun note", 32'(note_o), 1);

        // Loop length lowered below current step, then period 0
        do_reset();
        load_basic();
        set_cfg(2, 0, 15);
        run_i = 1'b1;
        for (int t = 0; t < 17; t++) begin
            tick();
            case (t)
                10: check("loop beat5", 32'(beat_count), 5);
                12: begin
                    check("loop wrap strobe", 32'(step_strobe_o), 1);
                    check("loop wrap beat", 32'(beat_count), 0);
                end
                13: check("loop hold strobe", 32'(step_strobe_o), 0);
                14, 15, 16: begin
                    check($sformatf("p0 strobe t=%0d", t), 32'(step_strobe_o), 1);
                    check($sformatf("p0 beat t=%0d", t), 32'(beat_count), (t - 13) % 3);
                    check($sformatf("p0 gate t=%0d", t), 32'(gate_o), 1);
                end
                default: ;
            endcase
            if (t == 10) loop_last_i = 4'd2;
            if (t == 12) step_period_i = '0;
        end

        // Reset mid-gate clears outputs and RAM
        do_reset();
        load_basic();
        set_cfg(4, 2, 3);
        run_i = 1'b1;
        tick();
        tick();
        check("pre-reset gate", 32'(gate_o), 1);
        rst   = 1'b1;
        run_i = 1'b0;
        tick();
        rst = 1'b0;
        check_idle("midreset");
        for (int i = 0; i < NUM_STEPS; i++) begin
            m_active[i] = 0;
            m_note[i]   = 0;
        end
        run_model("ram_cleared", 1, 0, 3, 4);

        // Writes: entry-edge write unseen, mid-step write deferred
        do_reset();
        load_basic();
        set_cfg(4, 0, 1);
        run_i = 1'b1;
        for (int t = 0; t < 13; t++) begin
            tick();
            wr_en_i = 1'b0;
            case (t)
                4:  check("rbw note", 32'(note_o), 2);
                6: begin
                    check("midwrite note", 32'(note_o), 2);
                    check("midwrite gate", 32'(gate_o), 1);
                end
                8:  check("wr step0 note", 32'(note_o), 1);
                12: begin
                    check("wr reentry note", 32'(note_o), 6);
                    check("wr reentry gate", 32'(gate_o), 0);
                end
                default: ;
            endcase
            if (t == 3 || t == 5) begin
                wr_en_i     = 1'b1;
                wr_addr_i   = 4'd1;
                wr_note_i   = (t == 3) ? 3'd7 : 3'd6;
                wr_active_i = (t == 3);
            end
        end

        // Mid-step tempo/gate change applies from the next step only
        do_reset();
        load_basic();
        set_cfg(4, 2, 3);
        run_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            check($sformatf("tempo strobe t=%0d", t), 32'(step_strobe_o),
                  (t == 0 || t == 4 || t == 6 || t == 8) ? 1 : 0);
            check($sformatf("tempo gate t=%0d", t), 32'(gate_o), (t == 2 || t == 3) ? 0 : 1);
            if (t == 1) set_cfg(2, 0, 3);
        end

`ifdef STEP_SEQUENCER_SWING_EN
        // Swing: durations 13,7,13,7 then clamped 19,1
        for (int s = 0; s < 2; s++) begin
            do_reset();
            load_basic();
            set_cfg(10, 0, 3);
            swing_i = (s == 0) ? 24'd3 : 24'd20;
            run_i = 1'b1;
            pos_q.delete();
            for (int t = 0; t < 40; t++) begin
                tick();
                if (step_strobe_o) pos_q.push_back(t);
            end
            if (s == 0) exp_q = '{0, 13, 20, 33};
            else        exp_q = '{0, 19, 20, 39};
            check($sformatf("swing%0d strobe count", s), pos_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < pos_q.size(); i++)
                check($sformatf("swing%0d strobe %0d", s, i), pos_q[i], exp_q[i]);
        end
        // Gate 12 against 13/7 durations: 12 + 7 high cycles
        do_reset();
        load_basic();
        set_cfg(10, 12, 3);
        swing_i = 24'd3;
        run_i = 1'b1;
        gate_hi = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            gate_hi += int'(gate_o);
        end
        check("swing gate_hi", gate_hi, 19);
        swing_i = '0;
`endif

        // Randomized runs against the reference model
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int a = 0; a < NUM_STEPS; a++)
                write_step(a, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            run_model($sformatf("rand%0d", it), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      int'($urandom_range(5, 40)));
        end

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
